norm_lzd_pipe: RTL and testbench

NORM_LZD_PIPE -- requirements
Module: norm_lzd_pipe

---
 rtl/norm_lzd_pkg.sv | 12 +
 rtl/lzd_count_comb.sv | 30 +++
 rtl/norm_lzd_pipe.sv | 80 ++++++++
 tb/tb_norm_lzd_pipe.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/norm_lzd_pkg.sv
// rtl/norm_lzd_pkg.sv - shared mode constants and count-width helper for the normaliser
package norm_lzd_pkg;

    localparam logic MODE_ONES  = 1'b0;
    localparam logic MODE_ZEROS = 1'b1;

    // Bits needed to hold a run length of 0..w inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/lzd_count_comb.sv
// rtl/lzd_count_comb.sv - combinational MSB-first leading-ones/zeros run counter
module lzd_count_comb
    import norm_lzd_pkg::*;
#(
    parameter int W  = 26,
    parameter int CW = cnt_width(W)
) (
    input  logic [W-1:0]  data,
    input  logic          mode,
    output logic [CW-1:0] count
);

    logic run_bit;
    logic hit;

    assign run_bit = (mode == MODE_ONES);

    // The first bit from the MSB that breaks the run fixes the count; no break means W.
    always_comb begin
        count = CW'(W);
        hit   = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!hit && (data[i] != run_bit)) begin
                count = CW'(W - 1 - i);
                hit   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/norm_lzd_pipe.sv
// rtl/norm_lzd_pipe.sv - 2-stage leading-run count and normalise pipeline; shifter under NORM_LZD_SHIFT_EN
module norm_lzd_pipe
    import norm_lzd_pkg::*;
#(
    parameter int W  = 26,
    parameter int CW = cnt_width(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  Data_Dec_i,
    input  logic          Mode_i,
    input  logic          Valid_i,
    output logic          Ready_o,
    output logic [CW-1:0] Data_Bin_o,
    output logic [W-1:0]  Data_Norm_o,
    output logic          All_Flag_o,
    output logic          Valid_o,
    input  logic          Ready_i
);

    logic          s1_valid;
    logic          s2_valid;
    logic [CW-1:0] s1_count;
    logic [CW-1:0] cnt_in;
    logic          s1_adv;
    logic          s2_adv;
    logic          accept;

    lzd_count_comb #(.W(W), .CW(CW)) u_count (
        .data  (Data_Dec_i),
        .mode  (Mode_i),
        .count (cnt_in)
    );

    assign s2_adv  = !s2_valid || Ready_i;
    assign s1_adv  = !s1_valid || s2_adv;
    assign Ready_o = !rst && s1_adv;
    assign accept  = Valid_i && Ready_o;
    assign Valid_o = s2_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            s1_count   <= '0;
            Data_Bin_o <= '0;
            All_Flag_o <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= accept;
                if (accept) s1_count <= cnt_in;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    Data_Bin_o <= s1_count;
                    All_Flag_o <= (s1_count == CW'(W));
                end
            end
        end
    end

`ifdef NORM_LZD_SHIFT_EN
    logic [W-1:0] s1_data;

    // A shift by W drops every bit, which gives the all-zero result for a full run.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data     <= '0;
            Data_Norm_o <= '0;
        end else begin
            if (s1_adv && accept) s1_data <= Data_Dec_i;
            if (s2_adv && s1_valid) Data_Norm_o <= s1_data << s1_count;
        end
    end
`else
    assign Data_Norm_o = '0;
`endif

endmodule

// File: tb/tb_norm_lzd_pipe.sv
// tb/tb_norm_lzd_pipe.sv - randomized and directed self-checking bench for norm_lzd_pipe
module tb_norm_lzd_pipe;

    localparam int W  = 26;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  Data_Dec_i;
    logic          Mode_i;
    logic          Valid_i;
    logic          Ready_o;
    logic [CW-1:0] Data_Bin_o;
    logic [W-1:0]  Data_Norm_o;
    logic          All_Flag_o;
    logic          Valid_o;
    logic          Ready_i;

    norm_lzd_pipe #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .Data_Dec_i  (Data_Dec_i),
        .Mode_i      (Mode_i),
        .Valid_i     (Valid_i),
        .Ready_o     (Ready_o),
        .Data_Bin_o  (Data_Bin_o),
        .Data_Norm_o (Data_Norm_o),
        .All_Flag_o  (All_Flag_o),
        .Valid_o     (Valid_o),
        .Ready_i     (Ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           bin;
        logic [W-1:0] norm;
        logic         flag;
        int           acc_cyc;
    } beat_t;

    beat_t        exp_q[$];
    int           checks   = 0;
    int           failures = 0;
    int           cyc_no   = 0;
    logic         chk_lat  = 1'b1;
    logic         held_pending = 1'b0;
    logic [CW-1:0] last_bin;
    logic [W-1:0] last_norm;
    logic         last_flag;
    logic         last_ready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Run length = W minus the bit length of the operand with run bits inverted to zeros.
    function automatic int ref_cnt(input logic [W-1:0] d, input logic m);
        logic [W-1:0] x;
        int           blen;
        x    = m ? d : ~d;
        blen = 0;
        for (int i = 0; i < W; i++) if (x[i]) blen = i + 1;
        return W - blen;
    endfunction

    function automatic beat_t ref_beat(input logic [W-1:0] d, input logic m, input int acc);
        beat_t b;
        b.bin  = ref_cnt(d, m);
        b.flag = (b.bin == W);
`ifdef NORM_LZD_SHIFT_EN
        b.norm = d << b.bin;
`else
        b.norm = '0;
`endif
        b.acc_cyc = acc;
        return b;
    endfunction

    task automatic cyc(input logic v, input logic [W-1:0] d, input logic m, input logic r,
                       output logic acc);
        beat_t e;
        Valid_i    = v;
        Data_Dec_i = d;
        Mode_i     = m;
        Ready_i    = r;
        #1;
        cyc_no++;
        last_ready = Ready_o;
        acc = Valid_i && Ready_o;
        if (held_pending) begin
            chk("held_valid", 64'(Valid_o), 64'd1);
            chk("held_bin", 64'(Data_Bin_o), 64'(last_bin));
            chk("held_norm", 64'(Data_Norm_o), 64'(last_norm));
            chk("held_flag", 64'(All_Flag_o), 64'(last_flag));
        end
        if (Valid_o && Ready_i) begin
            chk("spurious_beat", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("bin", 64'(Data_Bin_o), 64'(e.bin));
                chk("norm", 64'(Data_Norm_o), 64'(e.norm));
                chk("flag", 64'(All_Flag_o), 64'(e.flag));
                if (chk_lat) chk("latency", 64'(cyc_no - e.acc_cyc), 64'd2);
            end
        end
        if (acc) exp_q.push_back(ref_beat(d, m, cyc_no));
        held_pending = Valid_o && !Ready_i;
        last_bin  = Data_Bin_o;
        last_norm = Data_Norm_o;
        last_flag = All_Flag_o;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b1, a);
    endtask

    task automatic drain();
        logic a;
        int   n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            cyc(1'b0, '0, 1'b0, 1'b1, a);
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        idle(2);
    endtask

    task automatic one_beat(input logic [W-1:0] d, input logic m);
        logic a;
        chk_lat = 1'b1;
        cyc(1'b1, d, m, 1'b1, a);
        chk("one_beat_accept", 64'(a), 64'd1);
        idle(3);
        chk("one_beat_done", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic          a;
        logic [W-1:0]  bp_data [4];
        logic          bp_mode [4];
        int            idx;
        int            k;
        logic          stall_seen;
        logic [W-1:0]  d;
        logic          m;
        int            n;

        rst = 1'b1; Valid_i = 1'b0; Data_Dec_i = '0; Mode_i = 1'b0; Ready_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 64'(Valid_o), 64'd0);
        chk("rst_bin", 64'(Data_Bin_o), 64'd0);
        chk("rst_norm", 64'(Data_Norm_o), 64'd0);
        chk("rst_flag", 64'(All_Flag_o), 64'd0);
        chk("rst_ready", 64'(Ready_o), 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(Ready_o), 64'd1);
        @(negedge clk);

        one_beat(26'h0000000, 1'b0);
        one_beat(26'h3FFFFFE, 1'b0);
        one_beat(26'h0000001, 1'b1);
        one_beat(26'h3FFFFFF, 1'b0);
        one_beat(26'h0000000, 1'b1);
        one_beat(26'h2AAAAAA, 1'b1);

        // Counts 0, 5, 13, 26 with the sink stalled on calls 2..5.
        bp_data[0] = 26'h0000000; bp_mode[0] = 1'b0;
        bp_data[1] = 26'h0100000; bp_mode[1] = 1'b1;
        bp_data[2] = 26'h3FFE000; bp_mode[2] = 1'b0;
        bp_data[3] = 26'h3FFFFFF; bp_mode[3] = 1'b0;
        chk_lat = 1'b0;
        stall_seen = 1'b0;
        idx = 0;
        k = 1;
        while (k <= 20 && (idx < 4 || k <= 6)) begin
            if (idx < 4) cyc(1'b1, bp_data[idx], bp_mode[idx], !(k >= 2 && k <= 5), a);
            else         cyc(1'b0, '0, 1'b0, !(k >= 2 && k <= 5), a);
            if (!last_ready) stall_seen = 1'b1;
            if (a) idx++;
            k++;
        end
        chk("bp_all_accepted", 64'(idx), 64'd4);
        chk("bp_ready_low", 64'(stall_seen), 64'd1);
        drain();

        chk_lat = 1'b1;
        cyc(1'b1, 26'h0F00000, 1'b1, 1'b1, a);
        cyc(1'b1, 26'h3C00000, 1'b0, 1'b1, a);
        rst = 1'b1; Valid_i = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(Ready_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        held_pending = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(Valid_o), 64'd0);
        chk("mid_rst_ready_back", 64'(Ready_o), 64'd1);
        @(negedge clk);
        one_beat(26'h0004000, 1'b1);
        idle(3);

        chk_lat = 1'b0;
        for (int i = 0; i < 400; i++) begin
            m = 1'($urandom);
            d = W'($urandom);
            n = $urandom_range(0, W);
            for (int b = 0; b < n; b++) d[W-1-b] = !m;
            if (n < W) d[W-1-n] = m;
            cyc($urandom_range(0, 3) != 0, d, m, $urandom_range(0, 3) != 0, a);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
